// File: rtl/bitonic_pkg.sv
// Shared helpers for the bitonic sorter family: pipeline latency and lane slicing.
// The sorter, its stream controller and the bench all derive LATENCY from here.
package bitonic_pkg;

    function automatic int LATENCY_OF(input int chan_num, input int pipe_reg);
        int k;
        k = $clog2(chan_num);
        return (pipe_reg != 0) ? (k * (k + 1) / 2) : 0;
    endfunction

    function automatic int lane_lsb(input int lane, input int data_width);
        return lane * data_width;
    endfunction

endpackage

// File: rtl/bitonic_res_fifo.sv
// Result FIFO for sorted vectors. Head output reads zero while empty so m_data
// is clean after reset and flush without having to reset the storage array.
module bitonic_res_fifo #(
    parameter int WIDTH = 132,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_pop;

    assign w_pop = i_pop && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (i_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_valid = (r_cnt != '0);
    assign o_dout  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/bitonic_sort.sv
// Fixed-latency bitonic sorting network, ascending; one compare-exchange stage per
// pipeline register when PIPE_REG=1, fully combinational when PIPE_REG=0.
module bitonic_sort
    import bitonic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHAN_NUM   = 8,
    parameter int PIPE_REG   = 1
) (
    input  logic                           clk,
    input  logic [DATA_WIDTH*CHAN_NUM-1:0] data_in,
    output logic [DATA_WIDTH*CHAN_NUM-1:0] data_out
);
    localparam int K   = $clog2(CHAN_NUM);
    localparam int NST = LATENCY_OF(CHAN_NUM, 1);
    localparam int VW  = DATA_WIDTH * CHAN_NUM;

    // Stage s maps to merge phase p (block 2^(p+1)) and exchange distance 2^q.
    function automatic logic [VW-1:0] cas_stage(input int s, input logic [VW-1:0] v);
        logic [VW-1:0]         r;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  up;
        int                    p;
        int                    q;
        int                    n;
        int                    j;
        r = v;
        p = 0;
        q = 0;
        n = 0;
        for (int pp = 0; pp < K; pp++) begin
            for (int qq = pp; qq >= 0; qq--) begin
                if (n == s) begin
                    p = pp;
                    q = qq;
                end
                n++;
            end
        end
        for (int i = 0; i < CHAN_NUM; i++) begin
            j = i ^ (1 << q);
            if (j > i) begin
                a  = v[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
                b  = v[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
                up = (((i >> (p + 1)) & 1) == 0);
                if (up ? (a > b) : (a < b)) begin
                    r[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = b;
                    r[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = a;
                end
            end
        end
        return r;
    endfunction

    generate
        if (PIPE_REG != 0) begin : g_pipe
            logic [NST-1:0][VW-1:0] r_stg;
            always_ff @(posedge clk) begin
                r_stg[0] <= cas_stage(0, data_in);
                for (int s = 1; s < NST; s++) begin
                    r_stg[s] <= cas_stage(s, r_stg[s-1]);
                end
            end
            assign data_out = r_stg[NST-1];
        end else begin : g_comb
            always_comb begin
                logic [VW-1:0] w_v;
                w_v = data_in;
                for (int s = 0; s < NST; s++) begin
                    w_v = cas_stage(s, w_v);
                end
                data_out = w_v;
            end
        end
    endgenerate

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Valid/ready stream wrapper around the stall-free bitonic sorter: tracks valid and
// tag alongside the pipeline and only issues when a result FIFO slot is reserved.
module bitonic_sort_ctrl
    import bitonic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHAN_NUM   = 8,
    parameter int LATENCY    = LATENCY_OF(CHAN_NUM, 1),
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH*CHAN_NUM-1:0]   s_data,
    input  logic [TAG_W-1:0]                 s_tag,
    output logic [DATA_WIDTH*CHAN_NUM-1:0]   sort_din,
    input  logic [DATA_WIDTH*CHAN_NUM-1:0]   sort_dout,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH*CHAN_NUM-1:0]   m_data,
    output logic [TAG_W-1:0]                 m_tag,
    output logic [$clog2(LATENCY+1):0]       inflight,
    output logic                             busy
);
    localparam int VW   = DATA_WIDTH * CHAN_NUM;
    localparam int IFW  = $clog2(LATENCY + 1) + 1;
    localparam int FCW  = $clog2(FIFO_DEPTH) + 1;
    localparam int SUMW = ((IFW > FCW) ? IFW : FCW) + 1;

    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic [TAG_W-1:0]     w_push_tag;
    logic [FCW-1:0]       w_fifo_cnt;
    logic [SUMW-1:0]      w_credit_used;
    logic [VW+TAG_W-1:0]  w_head;
    logic [IFW-1:0]       r_inflight;

    // Credits come from registered counts only, so a same-cycle pop never re-opens s_ready.
    assign w_credit_used = SUMW'(r_inflight) + SUMW'(w_fifo_cnt);
    assign s_ready       = !flush && (w_credit_used < SUMW'(FIFO_DEPTH));
    assign w_accept      = s_valid && s_ready;
    assign sort_din      = w_accept ? s_data : '0;

    generate
        if (LATENCY > 0) begin : g_track
            logic [LATENCY-1:0]            r_vld;
            logic [LATENCY-1:0][TAG_W-1:0] r_tag;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_vld <= '0;
                    r_tag <= '0;
                end else begin
                    r_vld[0] <= w_accept;
                    r_tag[0] <= s_tag;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_vld[i] <= flush ? 1'b0 : r_vld[i-1];
                        r_tag[i] <= r_tag[i-1];
                    end
                end
            end
            assign w_push     = r_vld[LATENCY-1] && !flush;
            assign w_push_tag = r_tag[LATENCY-1];
        end else begin : g_bypass
            assign w_push     = w_accept;
            assign w_push_tag = s_tag;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= '0;
        end else if (flush) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= r_inflight + IFW'(w_accept) - IFW'(w_push);
        end
    end

    assign w_pop = m_valid && m_ready;

    bitonic_res_fifo #(
        .WIDTH (VW + TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (flush),
        .i_push  (w_push),
        .i_din   ({w_push_tag, sort_dout}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_valid (m_valid),
        .o_cnt   (w_fifo_cnt)
    );

    assign m_data   = w_head[VW-1:0];
    assign m_tag    = w_head[VW+TAG_W-1:VW];
    assign inflight = r_inflight;
    assign busy     = (r_inflight != '0) || m_valid;

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed bench for bitonic_sort_ctrl with the real pipelined sorter attached;
// a negedge scoreboard checks every popped result against a reference sort.
module tb_bitonic_sort_ctrl;
    import bitonic_pkg::*;

    localparam int DW  = 16;
    localparam int CN  = 8;
    localparam int TW  = 4;
    localparam int FD  = 8;
    localparam int LAT = LATENCY_OF(CN, 1);
    localparam int VW  = DW * CN;
    localparam int IFW = $clog2(LAT + 1) + 1;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           flush;
    logic           s_valid;
    logic           s_ready;
    logic [VW-1:0]  s_data;
    logic [TW-1:0]  s_tag;
    logic [VW-1:0]  sort_din;
    logic [VW-1:0]  sort_dout;
    logic           m_valid;
    logic           m_ready;
    logic [VW-1:0]  m_data;
    logic [TW-1:0]  m_tag;
    logic [IFW-1:0] inflight;
    logic           busy;

    always #5 clk = ~clk;

    bitonic_sort #(.DATA_WIDTH(DW), .CHAN_NUM(CN), .PIPE_REG(1)) u_sort (
        .clk      (clk),
        .data_in  (sort_din),
        .data_out (sort_dout)
    );

    bitonic_sort_ctrl #(
        .DATA_WIDTH (DW),
        .CHAN_NUM   (CN),
        .LATENCY    (LAT),
        .FIFO_DEPTH (FD),
        .TAG_W      (TW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_tag     (s_tag),
        .sort_din  (sort_din),
        .sort_dout (sort_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_tag     (m_tag),
        .inflight  (inflight),
        .busy      (busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_pops = 0;
    int n_acc = 0;
    int n_ovf = 0;

    typedef struct packed {
        logic [VW-1:0] d;
        logic [TW-1:0] t;
    } exp_t;
    exp_t sb_q[$];

    typedef struct packed {
        logic [VW-1:0] din;
        logic [TW-1:0] tag;
        logic [VW-1:0] exp;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [VW-1:0] pk(input int l0, input int l1, input int l2, input int l3,
                                         input int l4, input int l5, input int l6, input int l7);
        return {16'(l7), 16'(l6), 16'(l5), 16'(l4), 16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    function automatic logic [VW-1:0] ref_sort(input logic [VW-1:0] v);
        logic [DW-1:0] l [CN];
        logic [DW-1:0] t;
        logic [VW-1:0] r;
        for (int i = 0; i < CN; i++) l[i] = v[i*DW +: DW];
        for (int i = 0; i < CN; i++) begin
            for (int j = 0; j < CN - 1 - i; j++) begin
                if (l[j] > l[j+1]) begin
                    t = l[j];
                    l[j] = l[j+1];
                    l[j+1] = t;
                end
            end
        end
        for (int i = 0; i < CN; i++) r[i*DW +: DW] = l[i];
        return r;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < CN; i++) begin
            case ($urandom_range(0, 3))
                0:       r[i*DW +: DW] = 16'h0000;
                1:       r[i*DW +: DW] = 16'hFFFF;
                2:       r[i*DW +: DW] = 16'($urandom_range(0, 2));
                default: r[i*DW +: DW] = 16'($urandom);
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sample at negedge, when inputs are stable ahead of the next edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
        end else begin
            if (m_valid && m_ready) begin
                n_pops++;
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_pop: unexpected output %h tag %0d", m_data, m_tag);
                end else begin
                    chk("sb_data", m_data, sb_q[0].d);
                    chki("sb_tag", int'(m_tag), int'(sb_q[0].t));
                    void'(sb_q.pop_front());
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (s_valid && s_ready) begin
                n_acc++;
                sb_q.push_back({ref_sort(s_data), s_tag});
            end
            if (dut.w_fifo_cnt > FD) n_ovf++;
        end
    end

    task automatic run_single(input int k, input string nm);
        int lat;
        s_valid = 1'b1;
        s_data  = tbl[k].din;
        s_tag   = tbl[k].tag;
        #1;
        chki({nm, "_s_ready"}, int'(s_ready), 1);
        chk({nm, "_sort_din"}, sort_din, tbl[k].din);
        tick();
        chki({nm, "_inflight"}, int'(inflight), 1);
        s_valid = 1'b0;
        s_data  = '0;
        #1;
        chk({nm, "_din_idle"}, sort_din, '0);
        lat = 0;
        while (!m_valid && lat < 20) begin
            tick();
            lat++;
        end
        chki({nm, "_latency"}, lat, LAT);
        chk({nm, "_data"}, m_data, tbl[k].exp);
        chki({nm, "_tag"}, int'(m_tag), int'(tbl[k].tag));
        tick();
        chki({nm, "_valid_after"}, int'(m_valid), 0);
        chki({nm, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        int a0;
        int cnt;
        int cyc;

        tbl[0] = '{din: pk(7, 3, 5, 1, 8, 2, 6, 4),  tag: 4'd5,  exp: pk(1, 2, 3, 4, 5, 6, 7, 8)};
        tbl[1] = '{din: pk(8, 7, 6, 5, 4, 3, 2, 1),  tag: 4'd0,  exp: pk(1, 2, 3, 4, 5, 6, 7, 8)};
        tbl[2] = '{din: pk(5, 5, 5, 5, 5, 5, 5, 5),  tag: 4'd15, exp: pk(5, 5, 5, 5, 5, 5, 5, 5)};
        tbl[3] = '{din: pk('hFFFF, 0, 'hFFFF, 0, 1, 'hFFFE, 'h8000, 'h7FFF), tag: 4'd9,
                   exp: pk(0, 0, 1, 'h7FFF, 'h8000, 'hFFFE, 'hFFFF, 'hFFFF)};
        tbl[4] = '{din: pk(3, 1, 3, 1, 2, 2, 0, 9),  tag: 4'd3,  exp: pk(0, 1, 1, 2, 2, 3, 3, 9)};
        tbl[5] = '{din: pk(10, 20, 30, 40, 50, 60, 70, 80), tag: 4'd12,
                   exp: pk(10, 20, 30, 40, 50, 60, 70, 80)};

        reset_n = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_tag   = '0;
        m_ready = 1'b0;
        #2;
        chki("rst_m_valid", int'(m_valid), 0);
        chki("rst_inflight", int'(inflight), 0);
        chki("rst_busy", int'(busy), 0);
        #20;
        reset_n = 1'b1;
        #1;
        chki("rst_s_ready", int'(s_ready), 1);
        chk("rst_m_data", m_data, '0);
        chki("rst_m_tag", int'(m_tag), 0);
        tick();

        // Single vectors from the table, including equal keys and extremes.
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            run_single(k, $sformatf("t1_v%0d", k));
        end

        // Back-to-back stream.
        p0  = n_pops;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = {$urandom, $urandom, $urandom, $urandom};
            s_tag   = TW'(i % 16);
            #1;
            if (!s_ready) cnt++;
            tick();
        end
        s_valid = 1'b0;
        chki("t2_ready_drops", cnt, 0);
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        chki("t2_busy_end", int'(busy), 0);
        chki("t2_outputs", n_pops - p0, 20);

        // Backpressure fills exactly FIFO_DEPTH credits.
        m_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = {$urandom, $urandom, $urandom, $urandom};
            s_tag   = TW'(i);
            #1;
            if (s_ready) cnt++;
            tick();
        end
        s_valid = 1'b0;
        chki("t3_accepted", cnt, FD);
        chki("t3_s_ready", int'(s_ready), 0);
        chki("t3_inflight", int'(inflight), 0);
        chki("t3_fifo_cnt", int'(dut.w_fifo_cnt), FD);
        chki("t3_m_valid", int'(m_valid), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_data", m_data, sb_q[0].d);
            chki("t3_hold_tag", int'(m_tag), int'(sb_q[0].t));
        end
        m_ready = 1'b1;
        p0  = n_pops;
        cyc = 0;
        while (busy && cyc < 30) begin
            tick();
            cyc++;
        end
        chki("t3_drained", n_pops - p0, FD);
        chki("t3_busy_end", int'(busy), 0);

        // Flush with three vectors in flight.
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = tbl[i].din;
            s_tag   = TW'(i + 1);
            tick();
        end
        s_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        #1;
        chki("t4_ready_in_flush", int'(s_ready), 0);
        tick();
        flush = 1'b0;
        chki("t4_inflight", int'(inflight), 0);
        chki("t4_m_valid", int'(m_valid), 0);
        chki("t4_busy", int'(busy), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_valid) cnt++;
        end
        chki("t4_no_stale", cnt, 0);
        run_single(3, "t4_next");

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = {$urandom, $urandom, $urandom, $urandom};
            s_tag   = TW'(i);
            tick();
        end
        s_valid = 1'b0;
        chki("t5_pre_valid", int'(m_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chki("t5_m_valid", int'(m_valid), 0);
        chki("t5_inflight", int'(inflight), 0);
        chki("t5_busy", int'(busy), 0);
        #10;
        reset_n = 1'b1;
        #1;
        chki("t5_s_ready", int'(s_ready), 1);
        chk("t5_m_data", m_data, '0);
        chki("t5_m_tag", int'(m_tag), 0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (m_valid) cnt++;
        end
        chki("t5_no_stale", cnt, 0);

        // Random traffic with random backpressure.
        p0 = n_pops;
        a0 = n_acc;
        for (int i = 0; i < 300; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = rnd_vec();
            s_tag   = TW'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 50) begin
            tick();
            cyc++;
        end
        chki("t6_busy_end", int'(busy), 0);
        chki("t6_count", n_pops - p0, n_acc - a0);
        chki("t6_sb_empty", sb_q.size(), 0);
        chki("fifo_ovf", n_ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
